// File: rtl/audio_pkg.sv
// audio_pkg: shared scheduler state encoding and default codec/ROM widths.
package audio_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        XFER,
        GAP
    } state_t;

endpackage

// File: rtl/audio_lat_cnt.sv
// audio_lat_cnt: loadable down-counter that times the ROM address-to-data latency.
module audio_lat_cnt #(
    parameter int W = 2
) (
    input  logic         CLOCK_50,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = cnt == '0;

endmodule

// File: rtl/audio_sample_sched.sv
// audio_sample_sched: paces codec transfers from the mic ADC or a tone ROM into the DAC.
// AUDIO_SAMPLE_SCHED_LOOP_EN: defined wraps the ROM at end of table, undefined stops and raises play_done.
module audio_sample_sched
    import audio_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int ROM_DEPTH = 48000,
    parameter int ROM_LAT   = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              read_ready,
    input  logic              write_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    input  logic [DATA_W-1:0] rom_q,
    input  logic              src_sel,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              play_done
);

    state_t            state, state_nx;
    logic [1:0]        rst_sync;
    logic              run;
    logic              rom_mode;
    logic              cnt_load;
    logic              lat_done;
    logic              cap_mic;
    logic              cap_rom;
    logic              at_end;
    logic [ADDR_W-1:0] addr_end;
    logic              done_end;

    // Reset release is retimed so the FSM never leaves IDLE on a metastable release edge.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            rst_sync <= 2'b00;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end

    assign run = rst_sync[1];

    audio_lat_cnt #(.W(2)) u_lat_cnt (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (2'(ROM_LAT - 1)),
        .en       (state == FETCH),
        .done     (lat_done)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cnt_load = 1'b0;
        cap_mic  = 1'b0;
        cap_rom  = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
        case (state)
            IDLE: begin
                if (run && !src_sel && read_ready && write_ready) begin
                    state_nx = XFER;
                    cap_mic  = 1'b1;
                end else if (run && src_sel && write_ready && !play_done) begin
                    state_nx = FETCH;
                    cnt_load = 1'b1;
                end
            end
            FETCH: begin
                if (lat_done) begin
                    state_nx = XFER;
                    cap_rom  = 1'b1;
                end
            end
            XFER: begin
                state_nx = GAP;
                write    = 1'b1;
                read     = rom_mode ? read_ready : 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign at_end = rom_addr == ADDR_W'(ROM_DEPTH - 1);

`ifdef AUDIO_SAMPLE_SCHED_LOOP_EN
    assign addr_end = '0;
    assign done_end = 1'b0;
`else
    assign addr_end = rom_addr;
    assign done_end = 1'b1;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rom_mode        <= 1'b0;
            writedata_left  <= '0;
            writedata_right <= '0;
            rom_addr        <= '0;
            play_done       <= 1'b0;
        end else begin
            if (state == IDLE && run) begin
                rom_mode <= src_sel;
                if (!src_sel) begin
                    rom_addr  <= '0;
                    play_done <= 1'b0;
                end
            end
            if (cap_mic) begin
                writedata_left  <= readdata_left;
                writedata_right <= readdata_right;
            end
            if (cap_rom) begin
                writedata_left  <= rom_q;
                writedata_right <= rom_q;
            end
            if (state == XFER && rom_mode) begin
                rom_addr  <= at_end ? addr_end : rom_addr + 1'b1;
                play_done <= at_end ? done_end : play_done;
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_sched.sv
// tb_audio_sample_sched: scoreboard bench; stimulus queues expected transfers, a negedge monitor checks them.
module tb_audio_sample_sched;

    logic        CLOCK_50;
    logic        reset_n;
    logic        read_ready;
    logic        write_ready;
    logic [23:0] readdata_left;
    logic [23:0] readdata_right;
    logic [23:0] rom_q;
    logic        src_sel;
    logic        read;
    logic        write;
    logic [23:0] writedata_left;
    logic [23:0] writedata_right;
    logic [15:0] rom_addr;
    logic        play_done;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        rd;
        logic [15:0] addr;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    logic [15:0] p1, p2;

    audio_sample_sched #(
        .DATA_W    (24),
        .ADDR_W    (16),
        .ROM_DEPTH (4),
        .ROM_LAT   (2)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .reset_n         (reset_n),
        .read_ready      (read_ready),
        .write_ready     (write_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .rom_q           (rom_q),
        .src_sel         (src_sel),
        .read            (read),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .rom_addr        (rom_addr),
        .play_done       (play_done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Two-stage tone ROM whose word at address a is A00000 + a + 1.
    always @(posedge CLOCK_50) begin
        p1 <= rom_addr;
        p2 <= p1;
    end
    assign rom_q = 24'hA00000 + 24'(p2) + 24'd1;

    function automatic logic [23:0] rom_val(input logic [15:0] a);
        return 24'hA00000 + 24'(a) + 24'd1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_exp(input logic [23:0] l, input logic [23:0] r, input logic rd,
                            input logic [15:0] addr, input int c);
        exp_t e;
        e.l = l; e.r = r; e.rd = rd; e.addr = addr; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && q.size() != 0; i++)
            tick();
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL timeout: %0d transfers outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic rom_win(input bit expect_w, input logic [15:0] addr, input bit rd);
        repeat (3) tick();
        write_ready = 1'b1;
        read_ready  = rd;
        if (expect_w)
            push_exp(rom_val(addr), rom_val(addr), rd, addr, cyc + 3);
        tick();
        write_ready = 1'b0;
        if (expect_w)
            wait_done();
        else
            repeat (10) tick();
        read_ready = 1'b0;
    endtask

    always @(negedge CLOCK_50) begin
        if (write) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: got write=1 at cycle %0d, required 0", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("xfer_left", 64'(writedata_left), 64'(e.l));
                chk("xfer_right", 64'(writedata_right), 64'(e.r));
                chk("xfer_read", 64'(read), 64'(e.rd));
                chk("xfer_addr", 64'(rom_addr), 64'(e.addr));
                chk("xfer_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        int k;
        CLOCK_50       = 1'b0;
        reset_n        = 1'b1;
        read_ready     = 1'b0;
        write_ready    = 1'b0;
        src_sel        = 1'b0;
        readdata_left  = '0;
        readdata_right = '0;
        #2 reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_write", 64'(write), 64'(0));
        chk("rst_read", 64'(read), 64'(0));
        chk("rst_left", 64'(writedata_left), 64'(0));
        chk("rst_right", 64'(writedata_right), 64'(0));
        chk("rst_addr", 64'(rom_addr), 64'(0));
        chk("rst_done", 64'(play_done), 64'(0));

        // Release with mic readies already high: two sync cycles, then transfers 3 apart.
        readdata_left  = 24'h123456;
        readdata_right = 24'hABCDEF;
        read_ready     = 1'b1;
        write_ready    = 1'b1;
        reset_n        = 1'b1;
        k = cyc;
        push_exp(24'h123456, 24'hABCDEF, 1'b1, 16'd0, k + 3);
        push_exp(24'h654321, 24'hFEDCBA, 1'b1, 16'd0, k + 6);
        repeat (4) tick();
        readdata_left  = 24'h654321;
        readdata_right = 24'hFEDCBA;
        repeat (2) tick();
        read_ready  = 1'b0;
        write_ready = 1'b0;
        wait_done();
        repeat (4) tick();
        chk("mic_hold_left", 64'(writedata_left), 64'(24'h654321));
        chk("mic_addr", 64'(rom_addr), 64'(0));

        // Tone ROM playback through the end of the table.
        src_sel = 1'b1;
        rom_win(1'b1, 16'd0, 1'b0);
        chk("rom_addr_after_first", 64'(rom_addr), 64'(1));
        rom_win(1'b1, 16'd1, 1'b1);
        rom_win(1'b1, 16'd2, 1'b0);
        rom_win(1'b1, 16'd3, 1'b0);
`ifdef AUDIO_SAMPLE_SCHED_LOOP_EN
        chk("loop_wrap_addr", 64'(rom_addr), 64'(0));
        chk("loop_done", 64'(play_done), 64'(0));
        rom_win(1'b1, 16'd0, 1'b0);
        chk("loop_addr_after", 64'(rom_addr), 64'(1));
        chk("loop_done_after", 64'(play_done), 64'(0));
`else
        chk("end_done", 64'(play_done), 64'(1));
        chk("end_addr", 64'(rom_addr), 64'(3));
        rom_win(1'b0, 16'd3, 1'b0);
        chk("end_done_held", 64'(play_done), 64'(1));
        chk("end_addr_held", 64'(rom_addr), 64'(3));
`endif

        src_sel = 1'b0;
        repeat (3) tick();
        chk("clear_done", 64'(play_done), 64'(0));
        chk("clear_addr", 64'(rom_addr), 64'(0));

        // src_sel flipped during a mic XFER only takes effect at the next IDLE.
        readdata_left  = 24'h0F0F0F;
        readdata_right = 24'hF0F0F0;
        read_ready     = 1'b1;
        write_ready    = 1'b1;
        k = cyc;
        push_exp(24'h0F0F0F, 24'hF0F0F0, 1'b1, 16'd0, k + 1);
        push_exp(rom_val(16'd0), rom_val(16'd0), 1'b0, 16'd0, k + 6);
        tick();
        src_sel     = 1'b1;
        read_ready  = 1'b0;
        write_ready = 1'b0;
        repeat (2) tick();
        write_ready = 1'b1;
        tick();
        write_ready = 1'b0;
        wait_done();
        chk("switch_addr", 64'(rom_addr), 64'(1));

        // Reset in the middle of FETCH aborts the transfer and restarts at address 0.
        repeat (3) tick();
        write_ready = 1'b1;
        tick();
        write_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("abort_write", 64'(write), 64'(0));
        chk("abort_read", 64'(read), 64'(0));
        chk("abort_left", 64'(writedata_left), 64'(0));
        chk("abort_right", 64'(writedata_right), 64'(0));
        chk("abort_addr", 64'(rom_addr), 64'(0));
        chk("abort_done", 64'(play_done), 64'(0));
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        rom_win(1'b1, 16'd0, 1'b0);
        chk("restart_addr", 64'(rom_addr), 64'(1));

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule

// File: doc/audio_sample_sched.md
AUDIO_SAMPLE_SCHED -- requirements
Module: audio_sample_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 24, codec sample width per channel.
REQ-002 SHALL have parameter ADDR_W, default 16, tone ROM address width.
REQ-003 SHALL have parameter ROM_DEPTH, default 48000, number of valid ROM words.
REQ-004 SHALL have parameter ROM_LAT, default 2, ROM address-to-q latency in cycles (1..3).
REQ-005 SHALL have port CLOCK_50  input  1  sole clock, all logic on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port read_ready  input  1  codec ADC FIFO holds a sample pair.
REQ-008 SHALL have port write_ready  input  1  codec DAC FIFO can accept a sample pair.
REQ-009 SHALL have port readdata_left/readdata_right  input  DATA_W each  codec ADC samples.
REQ-010 SHALL have port rom_q  input  DATA_W  tone ROM output.
REQ-011 SHALL have port src_sel  input  1  0 = microphone passthrough, 1 = ROM playback.
REQ-012 SHALL have port read  output  1  one-cycle codec read pulse.
REQ-013 SHALL have port write  output  1  one-cycle codec write pulse.
REQ-014 SHALL have port writedata_left/writedata_right  output  DATA_W each  registered DAC samples.
REQ-015 SHALL have port rom_addr  output  ADDR_W  registered ROM address.
REQ-016 SHALL have port play_done  output  1  ROM playback exhausted (non-loop build only).

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, XFER, GAP.
REQ-018 SHALL latch src_sel only in IDLE; src_sel changes in other states are ignored until the next IDLE.
REQ-019 Mic mode: IDLE with read_ready & write_ready -> XFER; readdata_left/right captured into writedata_* on that edge.
REQ-020 ROM mode: IDLE with write_ready & ~play_done -> FETCH; FETCH holds exactly ROM_LAT cycles, then rom_q is captured into both writedata_* and state -> XFER.
REQ-021 XFER SHALL last exactly one cycle with write=1; read=1 in mic mode, and in ROM mode only if read_ready=1 (drains ADC FIFO).
REQ-022 XFER -> GAP unconditionally; GAP -> IDLE after one cycle, guaranteeing at most one transfer per 3 cycles in mic mode.
REQ-023 read and write SHALL be 0 in every state except XFER.
REQ-024 rom_addr SHALL increment by 1 on the XFER edge in ROM mode only; held otherwise.
REQ-025 At rom_addr = ROM_DEPTH-1, XFER SHALL apply the REQ-039 end-of-table behaviour instead of incrementing.
REQ-026 Latching src_sel=0 in IDLE SHALL clear rom_addr to 0 and clear play_done.
REQ-027 Mic-mode latency: ready seen at cycle N -> write pulse at N+1; ROM-mode latency: write_ready at N -> write at N+ROM_LAT+1.
REQ-028 writedata_* SHALL hold last transferred value between transfers.
REQ-029 If write_ready drops during FETCH, FSM SHALL still complete XFER (codec protocol tolerates one queued write).

Reset
REQ-030 reset_n=0 SHALL asynchronously force state IDLE, read=0, write=0, writedata_*=0, rom_addr=0, play_done=0.
REQ-031 Reset asserted mid-FETCH or mid-XFER SHALL abort the transfer with no write pulse; first transfer after release starts from rom_addr 0.
REQ-032 Release of reset_n SHALL be synchronized internally (two-flop) before state leaves IDLE.

Configuration
REQ-033 Macro AUDIO_SAMPLE_SCHED_LOOP_EN SHALL select end-of-table behaviour.
REQ-034 Defined: XFER at ROM_DEPTH-1 wraps rom_addr to 0; play_done tied 0.
REQ-035 Undefined: XFER at ROM_DEPTH-1 holds rom_addr and sets play_done=1; IDLE in ROM mode then issues no further ROM transfers until src_sel=0 latched or reset.
REQ-036 Both builds SHALL have identical ports.

Structure
REQ-037 Shared package audio_pkg SHALL hold the state enum (IDLE, FETCH, XFER, GAP) and DATA_W/ADDR_W defaults.
REQ-038 One sub-module audio_lat_cnt (ROM_LAT down-counter, load/done) is natural; all else inline.
REQ-039 End-of-table behaviour SHALL be one guarded region selected by the macro.

Verification
REQ-040 Mic: readdata_left=24'h123456, right=24'hABCDEF, both readies high at N -> write=read=1 at N+1, writedata matches, next transfer no earlier than N+3.
REQ-041 ROM, ROM_LAT=2: write_ready high at N, rom model returns addr+1 -> write at N+3, writedata=rom value for addr 0, rom_addr=1 afterwards.
REQ-042 Loop build, ROM_DEPTH=4: 5 transfers -> addresses 0,1,2,3,0; play_done stays 0.
REQ-043 Non-loop build, ROM_DEPTH=4: 5 write_ready windows -> 4 writes only, play_done=1 after 4th; src_sel=0 then clears play_done and rom_addr=0.
REQ-044 reset_n pulled low during FETCH -> no write, all outputs 0 immediately; after release, first ROM transfer uses addr 0.
REQ-045 src_sel toggled 0->1 during XFER -> current transfer completes as mic; next IDLE starts ROM flow.
